// File: rtl/imm_pkg.sv
// Shared types for the pipelined immediate generator: format encoding,
// RV base opcodes and default widths.
package imm_pkg;

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_SHAMT = 3'd2,
        FMT_S     = 3'd3,
        FMT_B     = 3'd4,
        FMT_U     = 3'd5,
        FMT_J     = 3'd6,
        FMT_ZIMM  = 3'd7
    } fmt_e;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

    localparam int DEF_XLEN  = 32;
    localparam int DEF_TAG_W = 5;

endpackage

// File: rtl/imm_gen_pipe_if.sv
// Input/output handshake bundle of imm_gen_pipe; master drives instructions
// and output backpressure, slave is the generator itself.
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    import imm_pkg::*;

    logic             in_valid_i;
    logic             in_ready_o;
    logic [31:0]      inst_code_i;
    logic [TAG_W-1:0] in_tag_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [XLEN-1:0]  imm_o;
    fmt_e             fmt_o;
    logic             illegal_o;
    logic [TAG_W-1:0] out_tag_o;

    modport master (
        output in_valid_i, inst_code_i, in_tag_i, out_ready_i,
        input  in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, out_tag_o
    );

    modport slave (
        input  in_valid_i, inst_code_i, in_tag_i, out_ready_i,
        output in_ready_o, out_valid_o, imm_o, fmt_o, illegal_o, out_tag_o
    );

endinterface

// File: rtl/imm_decode.sv
// Combinational RV32/RV64 immediate extraction and format classification.
module imm_decode #(
    parameter int XLEN       = 32,
    parameter bit EN_ILLEGAL = 1'b1
) (
    input  logic [31:0]      inst_code,
    output logic [XLEN-1:0]  imm,
    output imm_pkg::fmt_e    fmt,
    output logic             illegal
);
    import imm_pkg::*;

    localparam int SHW = $clog2(XLEN);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic       is_shift;

    assign opcode   = inst_code[6:0];
    assign f3       = inst_code[14:12];
    assign is_shift = (f3 == 3'b001) || (f3 == 3'b101);

    always_comb begin
        imm     = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        case (opcode)
            OPC_LOAD, OPC_JALR: begin
                imm = XLEN'($signed(inst_code[31:20]));
                fmt = FMT_I;
            end
            OPC_OP_IMM: begin
                // funct7 bits above the shamt are dropped, not sign-extended
                if (is_shift) begin
                    imm = XLEN'(inst_code[SHW+19:20]);
                    fmt = FMT_SHAMT;
                end else begin
                    imm = XLEN'($signed(inst_code[31:20]));
                    fmt = FMT_I;
                end
            end
            OPC_OP_IMM_32: begin
                if (XLEN == 64) begin
                    if (is_shift) begin
                        imm = XLEN'(inst_code[24:20]);
                        fmt = FMT_SHAMT;
                    end else begin
                        imm = XLEN'($signed(inst_code[31:20]));
                        fmt = FMT_I;
                    end
                end else begin
                    illegal = EN_ILLEGAL;
                end
            end
            OPC_STORE: begin
                imm = XLEN'($signed({inst_code[31:25], inst_code[11:7]}));
                fmt = FMT_S;
            end
            OPC_BRANCH: begin
                imm = XLEN'($signed({inst_code[31], inst_code[7], inst_code[30:25],
                                     inst_code[11:8], 1'b0}));
                fmt = FMT_B;
            end
            OPC_JAL: begin
                imm = XLEN'($signed({inst_code[31], inst_code[19:12], inst_code[20],
                                     inst_code[30:21], 1'b0}));
                fmt = FMT_J;
            end
            OPC_LUI, OPC_AUIPC: begin
                imm = XLEN'($signed({inst_code[31:12], 12'b0}));
                fmt = FMT_U;
            end
            OPC_SYSTEM: begin
                // CSR immediate forms carry zimm in rs1; others expose the CSR address unsigned
                if (f3[2]) begin
                    imm = XLEN'(inst_code[19:15]);
                    fmt = FMT_ZIMM;
                end else begin
                    imm = XLEN'(inst_code[31:20]);
                    fmt = FMT_I;
                end
            end
            default: begin
                illegal = EN_ILLEGAL;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a main output register and one skid
// entry so the consumer can stall without losing instructions.
module imm_gen_pipe #(
    parameter int XLEN       = 32,
    parameter int TAG_W      = 5,
    parameter bit EN_ILLEGAL = 1'b1
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    imm_gen_pipe_if.slave  bus
);
    import imm_pkg::*;

    if ((XLEN != 32) && (XLEN != 64)) begin : g_bad_xlen
        $error("imm_gen_pipe: XLEN must be 32 or 64");
    end

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } beat_t;

    logic [XLEN-1:0] dec_imm;
    fmt_e            dec_fmt;
    logic            dec_illegal;
    beat_t           in_beat;

    beat_t main_reg, main_next, skid_reg, skid_next;
    logic  main_valid_reg, main_valid_next;
    logic  skid_valid_reg, skid_valid_next;
    logic  push, pop;

    imm_decode #(
        .XLEN       (XLEN),
        .EN_ILLEGAL (EN_ILLEGAL)
    ) u_decode (
        .inst_code (bus.inst_code_i),
        .imm       (dec_imm),
        .fmt       (dec_fmt),
        .illegal   (dec_illegal)
    );

    assign in_beat = '{imm: dec_imm, fmt: dec_fmt, illegal: dec_illegal, tag: bus.in_tag_i};
    assign push    = bus.in_valid_i && !skid_valid_reg;
    assign pop     = main_valid_reg && bus.out_ready_i;

    always_comb begin
        main_next       = main_reg;
        main_valid_next = main_valid_reg;
        skid_next       = skid_reg;
        skid_valid_next = skid_valid_reg;
        if (skid_valid_reg) begin
            // input is blocked while skid is occupied; only a pop can make progress
            if (pop) begin
                main_next       = skid_reg;
                skid_valid_next = 1'b0;
            end
        end else if (push) begin
            if (!main_valid_reg || pop) begin
                main_next       = in_beat;
                main_valid_next = 1'b1;
            end else begin
                skid_next       = in_beat;
                skid_valid_next = 1'b1;
            end
        end else if (pop) begin
            main_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            main_reg       <= '0;
            skid_reg       <= '0;
            main_valid_reg <= 1'b0;
            skid_valid_reg <= 1'b0;
        end else begin
            main_reg       <= main_next;
            skid_reg       <= skid_next;
            main_valid_reg <= main_valid_next;
            skid_valid_reg <= skid_valid_next;
        end
    end

    assign bus.in_ready_o  = !skid_valid_reg;
    assign bus.out_valid_o = main_valid_reg;
    assign bus.imm_o       = main_reg.imm;
    assign bus.fmt_o       = main_reg.fmt;
    assign bus.illegal_o   = main_reg.illegal;
    assign bus.out_tag_o   = main_reg.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: directed cases plus random traffic on an XLEN=32
// and an XLEN=64 instance, scored against an arithmetic reference model.
module tb_imm_gen_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) if32 ();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) if64 ();

    imm_gen_pipe #(.XLEN(32), .TAG_W(5), .EN_ILLEGAL(1'b1)) dut32 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if32.slave));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5), .EN_ILLEGAL(1'b1)) dut64 (
        .clk_i (clk), .rst_ni (rst_n), .bus (if64.slave));

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [4:0]  tag;
    } exp_t;

    int checks = 0;
    int failures = 0;
    exp_t q32[$];
    exp_t q64[$];
    logic [4:0] popped[$];
    bit stall_prev = 0;
    logic [63:0] prev_imm;
    logic [2:0]  prev_fmt;
    logic [4:0]  prev_tag;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint sx(input longint v, input int bits);
        longint one = 1;
        return (v >= (one << (bits - 1))) ? v - (one << bits) : v;
    endfunction

    // Reference: each field assembled by weighted sums, then two's-complement folded.
    function automatic exp_t model(input logic [31:0] ins, input logic [4:0] tag, input int xlen);
        exp_t   e;
        longint v = 0;
        longint one = 1;
        int     op = int'(ins[6:0]);
        int     f3 = int'(ins[14:12]);
        bit     shift = (f3 == 1) || (f3 == 5);
        longint ifield = sx(longint'(ins >> 20), 12);
        e.fmt = 3'd0; e.ill = 1'b0; e.tag = tag;
        case (op)
            'h03, 'h67: begin v = ifield; e.fmt = 3'd1; end
            'h13: begin
                if (shift) begin v = longint'((ins >> 20) % 32'(xlen)); e.fmt = 3'd2; end
                else begin v = ifield; e.fmt = 3'd1; end
            end
            'h1B: begin
                if (xlen != 64) e.ill = 1'b1;
                else if (shift) begin v = longint'((ins >> 20) % 32); e.fmt = 3'd2; end
                else begin v = ifield; e.fmt = 3'd1; end
            end
            'h23: begin
                v = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12); e.fmt = 3'd3;
            end
            'h63: begin
                v = sx(longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048 +
                       longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2, 13);
                e.fmt = 3'd4;
            end
            'h6F: begin
                v = sx(longint'(ins[31]) * (one << 20) + longint'(ins[19:12]) * 4096 +
                       longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
                e.fmt = 3'd6;
            end
            'h37, 'h17: begin
                v = longint'(ins & 32'hFFFF_F000);
                if (ins[31]) v = v - (one << 32);
                e.fmt = 3'd5;
            end
            'h73: begin
                if (f3 >= 4) begin v = longint'((ins >> 15) % 32); e.fmt = 3'd7; end
                else begin v = longint'(ins >> 20); e.fmt = 3'd1; end
            end
            default: e.ill = 1'b1;
        endcase
        e.imm = (xlen == 32) ? {32'h0, v[31:0]} : 64'(v);
        return e;
    endfunction

    task automatic drive(input bit v, input logic [31:0] ins, input logic [4:0] tg, input bit ordy);
        if32.in_valid_i = v; if32.inst_code_i = ins; if32.in_tag_i = tg; if32.out_ready_i = ordy;
        if64.in_valid_i = v; if64.inst_code_i = ins; if64.in_tag_i = tg; if64.out_ready_i = ordy;
    endtask

    // Called at a negedge with inputs already set: score this cycle, then advance.
    task automatic cycle();
        exp_t e;
        bit push32 = if32.in_valid_i && if32.in_ready_o;
        bit pop32  = if32.out_valid_o && if32.out_ready_i;
        bit push64 = if64.in_valid_i && if64.in_ready_o;
        bit pop64  = if64.out_valid_o && if64.out_ready_i;
        check("rdy32", 64'(if32.in_ready_o), 64'(q32.size() < 2));
        check("vld32", 64'(if32.out_valid_o), 64'(q32.size() > 0));
        check("rdy64", 64'(if64.in_ready_o), 64'(q64.size() < 2));
        check("vld64", 64'(if64.out_valid_o), 64'(q64.size() > 0));
        if (stall_prev) begin
            check("stable_imm32", 64'(if32.imm_o), prev_imm);
            check("stable_fmt32", 64'(if32.fmt_o), 64'(prev_fmt));
            check("stable_tag32", 64'(if32.out_tag_o), 64'(prev_tag));
        end
        stall_prev = if32.out_valid_o && !if32.out_ready_i;
        prev_imm = 64'(if32.imm_o); prev_fmt = 3'(if32.fmt_o); prev_tag = if32.out_tag_o;
        if (pop32 && q32.size() > 0) begin
            e = q32.pop_front();
            check("imm32", 64'(if32.imm_o), e.imm);
            check("fmt32", 64'(if32.fmt_o), 64'(e.fmt));
            check("ill32", 64'(if32.illegal_o), 64'(e.ill));
            check("tag32", 64'(if32.out_tag_o), 64'(e.tag));
            popped.push_back(if32.out_tag_o);
        end
        if (pop64 && q64.size() > 0) begin
            e = q64.pop_front();
            check("imm64", if64.imm_o, e.imm);
            check("fmt64", 64'(if64.fmt_o), 64'(e.fmt));
            check("ill64", 64'(if64.illegal_o), 64'(e.ill));
            check("tag64", 64'(if64.out_tag_o), 64'(e.tag));
        end
        if (push32) q32.push_back(model(if32.inst_code_i, if32.in_tag_i, 32));
        if (push64) q64.push_back(model(if64.inst_code_i, if64.in_tag_i, 64));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic one(input logic [31:0] ins, input logic [4:0] tg);
        drive(1'b1, ins, tg, 1'b1);
        cycle();
        drive(1'b0, 32'h0, 5'd0, 1'b1);
    endtask

    logic [6:0] opc_tab [12] = '{7'h03, 7'h13, 7'h17, 7'h1B, 7'h23, 7'h37,
                                 7'h63, 7'h67, 7'h6F, 7'h73, 7'h0B, 7'h33};

    initial begin
        bit acc;
        logic [31:0] r;
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);

        check("rst_vld", 64'(if32.out_valid_o), 64'd0);
        check("rst_rdy", 64'(if32.in_ready_o), 64'd1);
        check("rst_imm", 64'(if32.imm_o), 64'd0);
        check("rst_fmt", 64'(if32.fmt_o), 64'd0);
        check("rst_ill", 64'(if32.illegal_o), 64'd0);
        check("rst_tag", 64'(if32.out_tag_o), 64'd0);

        one(32'hFFF0_0093, 5'd1);
        check("addi_imm", 64'(if32.imm_o), 64'h0000_0000_FFFF_FFFF);
        check("addi_fmt", 64'(if32.fmt_o), 64'd1);
        one(32'h4030_D093, 5'd2);
        check("srai_imm", 64'(if32.imm_o), 64'h3);
        check("srai_fmt", 64'(if32.fmt_o), 64'd2);
        one(32'hFE00_0EE3, 5'd3);
        check("beq_imm", 64'(if32.imm_o), 64'h0000_0000_FFFF_FFFC);
        check("beq_fmt", 64'(if32.fmt_o), 64'd4);
        one(32'h0000_006F, 5'd4);
        check("jal_imm", 64'(if32.imm_o), 64'h0);
        check("jal_fmt", 64'(if32.fmt_o), 64'd6);
        one(32'h8000_0037, 5'd5);
        check("lui64_imm", if64.imm_o, 64'hFFFF_FFFF_8000_0000);
        check("lui64_fmt", 64'(if64.fmt_o), 64'd5);
        one(32'h0000_000B, 5'd6);
        check("ill64", 64'(if64.illegal_o), 64'd1);
        check("ill64_fmt", 64'(if64.fmt_o), 64'd0);
        cycle();

        // Stalled consumer: two beats fill main+skid, third waits for room.
        popped.delete();
        drive(1'b1, 32'h0010_0093, 5'd1, 1'b0); cycle();
        drive(1'b1, 32'h0020_0093, 5'd2, 1'b0); cycle();
        drive(1'b1, 32'h0030_0093, 5'd3, 1'b0);
        check("skid_full_rdy", 64'(if32.in_ready_o), 64'd0);
        cycle();
        acc = 1'b0;
        for (int k = 0; k < 6 && !acc; k++) begin
            drive(1'b1, 32'h0030_0093, 5'd3, 1'b1);
            acc = if32.in_ready_o;
            cycle();
        end
        check("tag3_accepted", 64'(acc), 64'd1);
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        repeat (4) cycle();
        check("order_count", 64'(popped.size()), 64'd3);
        for (int k = 0; k < popped.size() && k < 3; k++)
            check("order_tag", 64'(popped[k]), 64'(k + 1));

        // Reset with both entries occupied.
        drive(1'b1, 32'h0070_0093, 5'd7, 1'b0); cycle();
        drive(1'b1, 32'h0080_0093, 5'd8, 1'b0); cycle();
        drive(1'b0, 32'h0, 5'd0, 1'b0);
        check("full_before_rst", 64'(if32.in_ready_o), 64'd0);
        rst_n = 1'b0;
        #1;
        check("rst_async_vld", 64'(if32.out_valid_o), 64'd0);
        check("rst_async_vld64", 64'(if64.out_valid_o), 64'd0);
        q32.delete();
        q64.delete();
        stall_prev = 0;
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_rdy", 64'(if32.in_ready_o), 64'd1);
        repeat (3) cycle();

        for (int n = 0; n < 600; n++) begin
            r = $urandom();
            drive($urandom_range(0, 3) != 0, {r[31:7], opc_tab[$urandom_range(0, 11)]},
                  5'($urandom_range(0, 31)), $urandom_range(0, 9) < 7);
            cycle();
        end
        drive(1'b0, 32'h0, 5'd0, 1'b1);
        repeat (4) cycle();
        check("drain32", 64'(q32.size()), 64'd0);
        check("drain64", 64'(q64.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
